// File: rtl/midi_note_ctrl_pkg.sv
// Shared constants, state encodings and the note-to-half-period formula
// for the MIDI note controller that feeds the floppy step generator.
package midi_note_ctrl_pkg;

    localparam int SETPOINT_W = 22;

    // Upper nibble of MIDI status bytes
    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] PROG       = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;
    localparam logic [3:0] SYS        = 4'hF;

    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    localparam logic [SETPOINT_W-1:0] SETPOINT_RST = 22'd56818;
    localparam logic [6:0]            NOTE_RST     = 7'd69;

    typedef enum logic [1:0] {
        S_STATUS = 2'd0,
        S_D1     = 2'd1,
        S_D2     = 2'd2
    } midi_state_e;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_ON   = 2'd1,
        ACT_OFF  = 2'd2
    } note_act_e;

    // Half-period in 50 MHz clk cycles for MIDI note n (A4 = 69 = 440 Hz).
    // Only ever evaluated with constant arguments, so it folds to a table.
    function automatic logic [SETPOINT_W-1:0] half_period(input int n);
        real ratio;
        real cycles;
        ratio  = 2.0 ** (real'(n - 69) / 12.0);
        cycles = 50.0e6 / (2.0 * 440.0 * ratio);
        return SETPOINT_W'($rtoi(cycles + 0.5));
    endfunction

endpackage

// File: rtl/midi_note_ctrl_rom.sv
// 128 x 22 synchronous note ROM: half-period for every MIDI note number,
// registered output with one cycle of latency.
module midi_note_rom
    import midi_note_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic [6:0]            addr,
    output logic [SETPOINT_W-1:0] data
);

    logic [SETPOINT_W-1:0] rom_tbl [128];

    for (genvar i = 0; i < 128; i++) begin : g_rom
        assign rom_tbl[i] = half_period(i);
    end

    always_ff @(posedge clk) begin
        data <= rom_tbl[addr];
    end

endmodule

// File: rtl/midi_note_ctrl.sv
// MIDI byte-stream parser driving setpoint/enable of one floppy step
// generator: monophonic, last-note priority, single channel.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_STATUS | no running status; data bytes are discarded
// S_D1     | waiting for first data byte (key / 1-byte payload)
// S_D2     | waiting for second data byte (velocity / 2nd payload)
module midi_note_ctrl
    import midi_note_ctrl_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int NOTE_LO = 24,
    parameter int NOTE_HI = 83
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  new_rx_data,
    output logic [SETPOINT_W-1:0] setpoint,
    output logic                  enable,
    output logic [6:0]            note
);

    localparam logic [3:0] CHAN   = 4'(CHANNEL);
    localparam logic [6:0] KEY_LO = 7'(NOTE_LO);
    localparam logic [6:0] KEY_HI = 7'(NOTE_HI);

    midi_state_e state_q;
    midi_state_e state_d;

    logic [7:0] run_status_q;
    logic [6:0] key_q;

    logic byte_sys;
    logic byte_status;
    logic byte_data;
    logic rs_chan_ok;
    logic rs_one_byte;
    logic key_in_range;
    logic key_load;

    note_act_e act_d;
    note_act_e p1_act_q;
    note_act_e p2_act_q;
    logic [6:0] p1_key_q;
    logic [6:0] p2_key_q;

    logic [SETPOINT_W-1:0] rom_data;

    assign byte_sys     = (rx_data[7:4] == SYS) && (rx_data < REALTIME_MIN);
    assign byte_status  = rx_data[7] && (rx_data[7:4] != SYS);
    assign byte_data    = ~rx_data[7];
    assign rs_chan_ok   = (run_status_q[3:0] == CHAN);
    assign rs_one_byte  = (run_status_q[7:4] == PROG) || (run_status_q[7:4] == CHAN_PRESS);
    assign key_in_range = (key_q >= KEY_LO) && (key_q <= KEY_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_STATUS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (new_rx_data) begin
            if (byte_sys) begin
                state_d = S_STATUS;
            end else if (byte_status) begin
                state_d = S_D1;
            end else if (byte_data) begin
                case (state_q)
                    S_D1:    state_d = rs_one_byte ? S_D1 : S_D2;
                    S_D2:    state_d = S_D1;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // Velocity zero on a note-on is a note-off
    always_comb begin
        key_load = new_rx_data && byte_data && (state_q == S_D1);
        act_d    = ACT_NONE;
        if (new_rx_data && byte_data && (state_q == S_D2) && rs_chan_ok) begin
            if ((run_status_q[7:4] == NOTE_ON) && (rx_data != 8'h00) && key_in_range) begin
                act_d = ACT_ON;
            end else if ((run_status_q[7:4] == NOTE_ON) || (run_status_q[7:4] == NOTE_OFF)) begin
                act_d = ACT_OFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_status_q <= 8'h00;
            key_q        <= 7'd0;
        end else begin
            if (new_rx_data && byte_sys) begin
                run_status_q <= 8'h00;
            end else if (new_rx_data && byte_status) begin
                run_status_q <= rx_data;
            end
            if (key_load) begin
                key_q <= rx_data[6:0];
            end
        end
    end

    // Two-stage pipeline keeps note-on and note-off aligned with the ROM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_act_q <= ACT_NONE;
            p2_act_q <= ACT_NONE;
            p1_key_q <= 7'd0;
            p2_key_q <= 7'd0;
        end else begin
            p1_act_q <= act_d;
            p1_key_q <= key_q;
            p2_act_q <= p1_act_q;
            p2_key_q <= p1_key_q;
        end
    end

    midi_note_rom u_rom (
        .clk  (clk),
        .addr (p1_key_q),
        .data (rom_data)
    );

    // Note-off compares against the note sounding at apply time, so a
    // back-to-back note-on ahead of it in the pipeline is honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setpoint <= SETPOINT_RST;
            note     <= NOTE_RST;
            enable   <= 1'b0;
        end else begin
            case (p2_act_q)
                ACT_ON: begin
                    setpoint <= rom_data;
                    note     <= p2_key_q;
                    enable   <= 1'b1;
                end
                ACT_OFF: begin
                    if (enable && (p2_key_q == note)) begin
                        enable <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_note_ctrl.sv
// Self-checking bench for midi_note_ctrl: message-level reference model with
// a per-cycle output compare plus hand-computed literal expectations.
module tb_midi_note_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        new_rx_data = 1'b0;
    logic [21:0] setpoint;
    logic        enable;
    logic [6:0]  note;

    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    midi_note_ctrl #(.CHANNEL(0), .NOTE_LO(24), .NOTE_HI(83)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .setpoint    (setpoint),
        .enable      (enable),
        .note        (note)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pitch from equal temperament, half of the period in 20 ns ticks
    function automatic int ref_half_period(input int n);
        real freq;
        freq = 440.0 * (2.0 ** (real'(n - 69) / 12.0));
        return $rtoi((50.0e6 / freq) / 2.0 + 0.5);
    endfunction

    // ---------------- reference model ----------------
    int m_status;
    int m_ndata;
    int m_key;
    int m_sp;
    int m_en;
    int m_note;
    int cyc;
    int pend_due[$];
    int pend_on[$];
    int pend_key[$];

    task automatic model_reset();
        m_status = -1;
        m_ndata  = 0;
        m_key    = 0;
        m_sp     = 56818;
        m_en     = 0;
        m_note   = 69;
        cyc      = 0;
        pend_due.delete();
        pend_on.delete();
        pend_key.delete();
    endtask

    task automatic model_byte(input int b);
        int hi;
        int ch;
        int len;
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin
            m_status = -1;
            return;
        end
        if (b >= 'h80) begin
            m_status = b;
            m_ndata  = 0;
            return;
        end
        if (m_status < 0) return;
        hi  = m_status / 16;
        ch  = m_status % 16;
        len = (hi == 'hC || hi == 'hD) ? 1 : 2;
        if (m_ndata == 0) m_key = b;
        m_ndata++;
        if (m_ndata < len) return;
        m_ndata = 0;
        if (len == 2 && ch == 0) begin
            if (hi == 9 && b != 0 && m_key >= 24 && m_key <= 83) begin
                pend_due.push_back(cyc + 2); pend_on.push_back(1); pend_key.push_back(m_key);
            end else if (hi == 8 || hi == 9) begin
                pend_due.push_back(cyc + 2); pend_on.push_back(0); pend_key.push_back(m_key);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            cyc++;
            while (pend_due.size() > 0 && pend_due[0] == cyc) begin
                if (pend_on[0] == 1) begin
                    m_note = pend_key[0];
                    m_sp   = ref_half_period(pend_key[0]);
                    m_en   = 1;
                end else if (m_en == 1 && m_note == pend_key[0]) begin
                    m_en = 0;
                end
                void'(pend_due.pop_front());
                void'(pend_on.pop_front());
                void'(pend_key.pop_front());
            end
            if (new_rx_data) model_byte(int'(rx_data));
        end
    end

    always @(negedge clk) begin
        chk("cyc_enable", int'(enable), m_en);
        chk("cyc_setpoint", int'(setpoint), m_sp);
        chk("cyc_note", int'(note), m_note);
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic drive(input logic [7:0] b);
        rx_data = b;
        new_rx_data = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        new_rx_data = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        drive(b);
        idle();
    endtask

    task automatic msg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(a);
        send(b);
        send(c);
        idle();
    endtask

    task automatic lit(input string name, input int sp, input int en, input int nt);
        chk({name, "_setpoint"}, int'(setpoint), sp);
        chk({name, "_enable"}, int'(enable), en);
        chk({name, "_note"}, int'(note), nt);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        lit("reset", 56818, 0, 69);
        rst_n = 1'b1;
        @(negedge clk);

        // First note and latency boundary
        send(8'h90); send(8'h45); send(8'h40);
        chk("lat_t1_enable", int'(enable), 0);
        idle();
        lit("a4_on", 56818, 1, 69);

        // Running status
        msg(8'h90, 8'h3C, 8'h40);
        lit("c4_on", 95556, 1, 60);
        send(8'h39); send(8'h40); idle();
        lit("rs_a3", 113636, 1, 57);

        // Note-off key matching, then velocity-zero off
        msg(8'h90, 8'h45, 8'h40);
        msg(8'h80, 8'h3C, 8'h00);
        lit("off_wrong_key", 56818, 1, 69);
        msg(8'h90, 8'h45, 8'h00);
        lit("vel0_off", 56818, 0, 69);

        // Channel and range filtering
        msg(8'h91, 8'h45, 8'h40);
        lit("other_chan", 56818, 0, 69);
        msg(8'h90, 8'h10, 8'h40);
        lit("below_lo", 56818, 0, 69);

        // Realtime interleave and sysex abort
        send(8'h90); send(8'h2D); send(8'hF8); send(8'h40); idle();
        lit("realtime", 227273, 1, 45);
        send(8'h90); send(8'h3C); send(8'hF0); send(8'h40); idle();
        lit("sys_abort", 227273, 1, 45);

        // Discarded 1- and 2-byte message kinds, then running status resumes
        send(8'hC0); send(8'h05); send(8'h07);
        send(8'hD0); send(8'h22);
        msg(8'hB0, 8'h3C, 8'h40);
        lit("discard", 227273, 1, 45);
        msg(8'h90, 8'h3C, 8'h40);
        lit("after_discard", 95556, 1, 60);

        // Range boundaries
        msg(8'h90, 8'd24, 8'h40);
        chk("lo_edge_note", int'(note), 24);
        msg(8'h90, 8'd23, 8'h40);
        chk("lo_out_note", int'(note), 24);
        msg(8'h90, 8'd83, 8'h40);
        chk("hi_edge_note", int'(note), 83);
        msg(8'h90, 8'd84, 8'h40);
        chk("hi_out_note", int'(note), 83);

        // Back-to-back strobes: last note wins, then on/off pair
        drive(8'h90); drive(8'h45); drive(8'h40); drive(8'h3C); drive(8'h40);
        idle(); idle(); idle();
        lit("b2b_last", 95556, 1, 60);
        drive(8'h90); drive(8'h45); drive(8'h40); drive(8'h80); drive(8'h45); drive(8'h00);
        idle(); idle(); idle();
        lit("b2b_onoff", 56818, 0, 69);

        // Off on another channel does nothing
        msg(8'h90, 8'h3C, 8'h40);
        msg(8'h81, 8'h3C, 8'h00);
        lit("off_other_chan", 95556, 1, 60);

        // Reset with a half-received message
        send(8'h90); send(8'h45);
        #3 rst_n = 1'b0;
        #1 lit("async_rst", 56818, 0, 69);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h45); send(8'h40); idle(); idle();
        lit("post_rst_data", 56818, 0, 69);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
